// File: rtl/core_pkg.sv
// Shared writeback types: register address/data widths, source indices and the
// buffered result entry used by every per-source FIFO.
package core_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int DATA_W     = 32;
  localparam int NUM_SRC    = 3;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_FPU = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     val;
  } wb_entry_t;

  // Cyclic successor in the ALU -> FPU -> MEM search order.
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_MEM) ? SRC_ALU : s + 2'd1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO. Full/empty come from the occupancy count; a push on a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  wb_entry_t        mem_q [DEPTH];

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    count    = count_q;
    dout     = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read unless count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three buffered producers share one register-file write port,
// granted round-robin. Optional contention counter under WB_CONFLICT_CNT_EN.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_dd_val,
  input  logic [REG_ADDR_W-1:0] fpu_addr,
  input  logic [DATA_W-1:0]     fpu_dd_val,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_dd_val,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_val,
  output logic                  alu_stall,
  output logic                  fpu_stall,
  output logic                  mem_stall,
`ifdef WB_CONFLICT_CNT_EN
  output logic [31:0]           wb_conflict_cnt,
`endif
  output logic                  ovf
);

  // Producer handshake: a nonzero addr is a valid result and is pushed at the
  // next edge; the producer must hold off while its stall is high, with one
  // slot of slack for a result already in its output register.
  logic [NUM_SRC-1:0] push, pop, empty, full;
  wb_entry_t          din  [NUM_SRC];
  wb_entry_t          head [NUM_SRC];
  logic [CNT_W-1:0]   cnt  [NUM_SRC];

  logic [1:0] last_grant_q, last_grant_d;
  logic       ovf_q, ovf_d;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [1:0] cand;

  always_comb begin
    din[SRC_ALU] = '{addr: alu_addr, val: alu_dd_val};
    din[SRC_FPU] = '{addr: fpu_addr, val: fpu_dd_val};
    din[SRC_MEM] = '{addr: mem_addr, val: mem_dd_val};
    push[SRC_ALU] = (alu_addr != '0);
    push[SRC_FPU] = (fpu_addr != '0);
    push[SRC_MEM] = (mem_addr != '0);
  end

  wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_alu_fifo (
    .clk(clk), .rstn(rstn), .push(push[SRC_ALU]), .pop(pop[SRC_ALU]),
    .din(din[SRC_ALU]), .dout(head[SRC_ALU]), .count(cnt[SRC_ALU]),
    .empty(empty[SRC_ALU]), .full(full[SRC_ALU])
  );

  wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fpu_fifo (
    .clk(clk), .rstn(rstn), .push(push[SRC_FPU]), .pop(pop[SRC_FPU]),
    .din(din[SRC_FPU]), .dout(head[SRC_FPU]), .count(cnt[SRC_FPU]),
    .empty(empty[SRC_FPU]), .full(full[SRC_FPU])
  );

  wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_mem_fifo (
    .clk(clk), .rstn(rstn), .push(push[SRC_MEM]), .pop(pop[SRC_MEM]),
    .din(din[SRC_MEM]), .dout(head[SRC_MEM]), .count(cnt[SRC_MEM]),
    .empty(empty[SRC_MEM]), .full(full[SRC_MEM])
  );

  // Search starts just after the last granted source.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = SRC_ALU;
    cand        = next_src(last_grant_q);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
      cand = next_src(cand);
    end

    pop     = '0;
    wr_en   = grant_valid;
    wr_addr = '0;
    wr_val  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = grant_valid && (grant_idx == 2'(i));
      if (pop[i]) begin
        wr_addr = head[i].addr;
        wr_val  = head[i].val;
      end
    end

    last_grant_d = grant_valid ? grant_idx : last_grant_q;
    ovf_d        = ovf_q | (|(push & full & ~pop));

    alu_stall = (cnt[SRC_ALU] >= CNT_W'(DEPTH - 1));
    fpu_stall = (cnt[SRC_FPU] >= CNT_W'(DEPTH - 1));
    mem_stall = (cnt[SRC_MEM] >= CNT_W'(DEPTH - 1));
    ovf       = ovf_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= SRC_MEM;
      ovf_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef WB_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic        conflict;

  // Two or more buffered sources means at least one result waited this cycle.
  always_comb begin
    conflict = (!empty[0] && !empty[1]) || (!empty[0] && !empty[2]) ||
               (!empty[1] && !empty[2]);
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) conflict_cnt_d = conflict_cnt_q + 32'd1;
    wb_conflict_cnt = conflict_cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) conflict_cnt_q <= '0;
    else       conflict_cnt_q <= conflict_cnt_d;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single source, zero address, collision order,
// stall/overflow with drain order, and asynchronous reset mid-drain.
module tb_wb_arbiter;

  logic        clk;
  logic        rstn;
  logic [5:0]  alu_addr, fpu_addr, mem_addr;
  logic [31:0] alu_dd_val, fpu_dd_val, mem_dd_val;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_val;
  logic        alu_stall, fpu_stall, mem_stall, ovf;
`ifdef WB_CONFLICT_CNT_EN
  logic [31:0] wb_conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rstn(rstn),
    .alu_addr(alu_addr), .alu_dd_val(alu_dd_val),
    .fpu_addr(fpu_addr), .fpu_dd_val(fpu_dd_val),
    .mem_addr(mem_addr), .mem_dd_val(mem_dd_val),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_val(wr_val),
    .alu_stall(alu_stall), .fpu_stall(fpu_stall), .mem_stall(mem_stall),
`ifdef WB_CONFLICT_CNT_EN
    .wb_conflict_cnt(wb_conflict_cnt),
`endif
    .ovf(ovf)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic drive(input logic [5:0] aa, input logic [31:0] av,
                       input logic [5:0] fa, input logic [31:0] fv,
                       input logic [5:0] ma, input logic [31:0] mv);
    alu_addr = aa; alu_dd_val = av;
    fpu_addr = fa; fpu_dd_val = fv;
    mem_addr = ma; mem_dd_val = mv;
  endtask

  task automatic idle();
    drive(6'd0, 32'd0, 6'd0, 32'd0, 6'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [5:0] a, input logic [31:0] v);
    chk({tag, "_en"}, 32'(wr_en), 32'(en));
    chk({tag, "_addr"}, 32'(wr_addr), 32'(a));
    chk({tag, "_val"}, wr_val, v);
  endtask

  initial begin
    rstn = 1'b0;
    idle();

    // Reset state
    do_reset();
    chk_wr("rst", 1'b0, 6'd0, 32'd0);
    chk("rst_alu_stall", 32'(alu_stall), 32'd0);
    chk("rst_fpu_stall", 32'(fpu_stall), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Single source: one-cycle latency, then idle
    drive(6'd5, 32'h1234, 6'd0, 32'd0, 6'd0, 32'd0);
    @(negedge clk);
    chk_wr("single", 1'b1, 6'd5, 32'h1234);
    idle();
    @(negedge clk);
    chk_wr("single_after", 1'b0, 6'd0, 32'd0);
`ifdef WB_CONFLICT_CNT_EN
    chk("single_conflict_cnt", wb_conflict_cnt, 32'd0);
`endif

    // Zero address is never enqueued
    drive(6'd0, 32'd0, 6'd0, 32'hDEADBEEF, 6'd0, 32'd0);
    @(negedge clk);
    chk_wr("zero_addr", 1'b0, 6'd0, 32'd0);
    chk("zero_fpu_count", 32'(dut.u_fpu_fifo.count), 32'd0);
    idle();
    @(negedge clk);
    chk("zero_after_en", 32'(wr_en), 32'd0);

    // Three-way collision from reset: ALU, FPU, MEM in order
    do_reset();
    drive(6'd3, 32'hA, 6'd40, 32'hB, 6'd7, 32'hC);
    @(negedge clk);
    chk_wr("coll_0", 1'b1, 6'd3, 32'hA);
    idle();
    @(negedge clk);
    chk_wr("coll_1", 1'b1, 6'd40, 32'hB);
    @(negedge clk);
    chk_wr("coll_2", 1'b1, 6'd7, 32'hC);
    @(negedge clk);
    chk_wr("coll_done", 1'b0, 6'd0, 32'd0);
`ifdef WB_CONFLICT_CNT_EN
    chk("coll_conflict_cnt", wb_conflict_cnt, 32'd2);
`endif

    // Stall and overflow: MEM pushes every cycle while ALU/FPU hold grants
    do_reset();
    drive(6'd1, 32'd11, 6'd33, 32'd21, 6'd9, 32'd100);
    @(negedge clk);
    chk_wr("so_c1", 1'b1, 6'd1, 32'd11);
    chk("so_c1_stall", 32'(mem_stall), 32'd0);
    drive(6'd2, 32'd12, 6'd34, 32'd22, 6'd9, 32'd101);
    @(negedge clk);
    chk_wr("so_c2", 1'b1, 6'd33, 32'd21);
    chk("so_c2_stall", 32'(mem_stall), 32'd0);
    chk("so_c2_fpu_stall", 32'(fpu_stall), 32'd0);
    drive(6'd0, 32'd0, 6'd0, 32'd0, 6'd9, 32'd102);
    @(negedge clk);
    chk_wr("so_c3", 1'b1, 6'd9, 32'd100);
    chk("so_c3_stall", 32'(mem_stall), 32'd1);
    drive(6'd0, 32'd0, 6'd0, 32'd0, 6'd9, 32'd103);
    @(negedge clk);
    chk_wr("so_c4", 1'b1, 6'd2, 32'd12);
    chk("so_c4_stall", 32'(mem_stall), 32'd1);
    drive(6'd0, 32'd0, 6'd0, 32'd0, 6'd9, 32'd104);
    @(negedge clk);
    chk_wr("so_c5", 1'b1, 6'd34, 32'd22);
    chk("so_c5_ovf", 32'(ovf), 32'd0);
    drive(6'd0, 32'd0, 6'd0, 32'd0, 6'd9, 32'd105);
    @(negedge clk);
    chk_wr("so_c6", 1'b1, 6'd9, 32'd101);
    chk("so_c6_ovf", 32'(ovf), 32'd1);
    chk("so_c6_stall", 32'(mem_stall), 32'd1);
    idle();
    @(negedge clk);
    chk_wr("so_c7", 1'b1, 6'd9, 32'd102);
    chk("so_c7_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    chk_wr("so_c8", 1'b1, 6'd9, 32'd103);
    chk("so_c8_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    chk_wr("so_c9", 1'b1, 6'd9, 32'd104);
    @(negedge clk);
    chk_wr("so_c10", 1'b0, 6'd0, 32'd0);
    chk("so_c10_ovf_sticky", 32'(ovf), 32'd1);

    // Reset mid-drain
    do_reset();
    drive(6'd4, 32'h40, 6'd35, 32'h50, 6'd0, 32'd0);
    @(negedge clk);
    chk_wr("rd_c1", 1'b1, 6'd4, 32'h40);
    drive(6'd5, 32'h41, 6'd36, 32'h51, 6'd0, 32'd0);
    @(negedge clk);
    chk_wr("rd_c2", 1'b1, 6'd35, 32'h50);
    drive(6'd0, 32'd0, 6'd37, 32'h52, 6'd0, 32'd0);
    @(negedge clk);
    chk_wr("rd_c3", 1'b1, 6'd5, 32'h41);
    idle();
    #2 rstn = 1'b0;
    #1;
    chk_wr("rd_async", 1'b0, 6'd0, 32'd0);
    chk("rd_async_fpu_stall", 32'(fpu_stall), 32'd0);
    chk("rd_async_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    chk("rd_rel_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    chk_wr("rd_post", 1'b0, 6'd0, 32'd0);
    chk("rd_post_fpu_count", 32'(dut.u_fpu_fifo.count), 32'd0);
    drive(6'd6, 32'h66, 6'd0, 32'd0, 6'd0, 32'd0);
    @(negedge clk);
    chk_wr("rd_new", 1'b1, 6'd6, 32'h66);
    idle();
    @(negedge clk);
    chk_wr("rd_new_after", 1'b0, 6'd0, 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
